// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
//   Sequential load/store unit sitting between the datapath and a handshaked
//   data-memory bus. Each access checks legality and alignment, generates byte
//   enables and lane-replicated store data, and runs a single bus transaction
//   guarded by a watchdog. Loads are sign or zero extended from the addressed
//   lane. The core is stalled through o_busy until the one-cycle o_done pulse.
//
// Parameters
//   TIMEOUT      max cycles o_bus_req stays high without i_bus_ack (2..255)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_mem_req    single-cycle access request, sampled only when idle
//   i_mem_we     1 = store, 0 = load
//   i_dm_type    000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
//   i_addr       byte address
//   i_wdata      store data (low bits used for half/byte)
//   o_busy       access in progress
//   o_done       one-cycle completion pulse
//   o_err        qualifies o_done: misaligned, illegal or timed out
//   o_rdata      extended load result, held until the next o_done
//   o_bus_req    bus request, held until ack or timeout
//   o_bus_we     bus write strobe
//   o_bus_addr   word-aligned bus address
//   o_bus_be     byte enables
//   o_bus_wdata  lane-replicated store data
//   i_bus_rdata  bus read data, valid with i_bus_ack
//   i_bus_ack    transaction complete, ignored unless o_bus_req is high
// -----------------------------------------------------------------------------
module dm_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [2:0]  i_dm_type,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    // Watchdog value at which the final REQ cycle is reached.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    // ---------------------------------------------------------------------
    // Access helpers
    // ---------------------------------------------------------------------

    // Legal type/direction combination with natural alignment.
    function automatic logic access_ok(input logic we, input logic [2:0] t,
                                       input logic [1:0] lo);
        logic ok;
        case (t)
            DM_W:    ok = (lo == 2'b00);
            DM_H:    ok = ~lo[0];
            DM_HU:   ok = ~we & ~lo[0];
            DM_B:    ok = 1'b1;
            DM_BU:   ok = ~we;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] gen_be(input logic [2:0] t, input logic [1:0] lo);
        logic [3:0] be;
        case (t)
            DM_W:        be = 4'b1111;
            DM_H, DM_HU: be = lo[1] ? 4'b1100 : 4'b0011;
            DM_B, DM_BU: begin
                case (lo)
                    2'b00:   be = 4'b0001;
                    2'b01:   be = 4'b0010;
                    2'b10:   be = 4'b0100;
                    2'b11:   be = 4'b1000;
                    default: be = 4'b0000;
                endcase
            end
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store data into every lane so the byte enables alone
    // select where it lands.
    function automatic logic [31:0] gen_wdata(input logic [2:0] t, input logic [31:0] d);
        logic [31:0] res;
        case (t)
            DM_W:        res = d;
            DM_H, DM_HU: res = {d[15:0], d[15:0]};
            DM_B, DM_BU: res = {d[7:0], d[7:0], d[7:0], d[7:0]};
            default:     res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [1:0] lo,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            2'b11:   b = d[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? d[31:16] : d[15:0];
        case (t)
            DM_W:    res = d;
            DM_H:    res = {{16{h[15]}}, h};
            DM_HU:   res = {16'h0000, h};
            DM_B:    res = {{24{b[7]}}, b};
            DM_BU:   res = {24'h00_0000, b};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // ---------------------------------------------------------------------
    // State and registers
    // ---------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_wd;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_dm_type;

    state_t      w_state_nxt;
    logic [7:0]  w_wd_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_bus_req_nxt;
    logic        w_bus_we_nxt;
    logic [31:0] w_bus_addr_nxt;
    logic [3:0]  w_bus_be_nxt;
    logic [31:0] w_bus_wdata_nxt;
    logic [1:0]  w_addr_lo_nxt;
    logic [2:0]  w_dm_type_nxt;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-register-value decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_wd_nxt        = r_wd;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_be_nxt    = r_bus_be;
        w_bus_wdata_nxt = r_bus_wdata;
        w_addr_lo_nxt   = r_addr_lo;
        w_dm_type_nxt   = r_dm_type;

        case (r_state)
            ST_IDLE: begin
                if (i_mem_req) begin
                    if (access_ok(i_mem_we, i_dm_type, i_addr[1:0])) begin
                        w_state_nxt     = ST_REQ;
                        w_wd_nxt        = 8'd0;
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = i_mem_we;
                        w_bus_addr_nxt  = {i_addr[31:2], 2'b00};
                        w_bus_be_nxt    = gen_be(i_dm_type, i_addr[1:0]);
                        w_bus_wdata_nxt = gen_wdata(i_dm_type, i_wdata);
                        w_addr_lo_nxt   = i_addr[1:0];
                        w_dm_type_nxt   = i_dm_type;
                    end else begin
                        // Rejected before any bus activity.
                        w_state_nxt = ST_FAIL;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = 32'h0000_0000;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Ack is tested first so an ack in the expiring cycle wins.
                if (i_bus_ack) begin
                    w_state_nxt   = ST_RESP;
                    w_wd_nxt      = 8'd0;
                    w_bus_req_nxt = 1'b0;
                    w_bus_we_nxt  = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = 1'b0;
                    if (r_bus_we) begin
                        w_rdata_nxt = 32'h0000_0000;
                    end else begin
                        w_rdata_nxt = load_extend(r_dm_type, r_addr_lo, i_bus_rdata);
                    end
                end else if (r_wd == WD_LAST) begin
                    w_state_nxt   = ST_FAIL;
                    w_wd_nxt      = 8'd0;
                    w_bus_req_nxt = 1'b0;
                    w_bus_we_nxt  = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = 1'b1;
                    w_rdata_nxt   = 32'h0000_0000;
                end else begin
                    w_wd_nxt = r_wd + 8'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FAIL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_wd_nxt      = 8'd0;
                w_bus_req_nxt = 1'b0;
                w_bus_we_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd        <= 8'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_addr_lo   <= 2'b00;
            r_dm_type   <= 3'b000;
        end else begin
            r_wd        <= w_wd_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_rdata     <= w_rdata_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_be    <= w_bus_be_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_addr_lo   <= w_addr_lo_nxt;
            r_dm_type   <= w_dm_type_nxt;
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_be    = r_bus_be;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_access_unit
//   Self-checking bench for dm_access_unit with TIMEOUT=4. Each scenario task
//   pushes its expected completion onto a scoreboard queue, drives the access,
//   pops the expectation when o_done is observed and compares inline.
// -----------------------------------------------------------------------------
module tb_dm_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_mem_req;
    logic        i_mem_we;
    logic [2:0]  i_dm_type;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          lat;
        int          req_cycles;
        int          done_cyc;
        logic        done_seen;
        logic        err;
        logic [31:0] rdata;
        logic        busy;
        logic        bwe;
        logic [31:0] baddr;
        logic [3:0]  bbe;
        logic [31:0] bwdata;
        logic        stable;
    } obs_t;

    exp_t sb_q[$];

    dm_access_unit #(.TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_mem_req   (i_mem_req),
        .i_mem_we    (i_mem_we),
        .i_dm_type   (i_dm_type),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rdata     (o_rdata),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_be    (o_bus_be),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_rdata (i_bus_rdata),
        .i_bus_ack   (i_bus_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one access; ack_at is the 1-based REQ cycle carrying the ack
    // (0 = never). Returns what was seen; ends in the cycle after o_done.
    task automatic run_access(input logic we, input logic [2:0] t,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] brd,
                              output obs_t o);
        o = '{default: '0};
        o.stable = 1'b1;
        i_mem_req = 1'b1;
        i_mem_we  = we;
        i_dm_type = t;
        i_addr    = a;
        i_wdata   = wd;
        tick();
        i_mem_req = 1'b0;
        i_mem_we  = 1'b0;
        i_dm_type = 3'b000;
        i_addr    = 32'h0;
        i_wdata   = 32'h0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (o_done === 1'b1) begin
                o.done_seen = 1'b1;
                o.lat       = cyc;
                o.done_cyc  = cyc_cnt;
                o.err       = o_err;
                o.rdata     = o_rdata;
                o.busy      = o_busy;
                break;
            end
            if (o_bus_req === 1'b1) begin
                o.req_cycles++;
                if (o.req_cycles == 1) begin
                    o.bwe    = o_bus_we;
                    o.baddr  = o_bus_addr;
                    o.bbe    = o_bus_be;
                    o.bwdata = o_bus_wdata;
                end else if (o_bus_we !== o.bwe || o_bus_addr !== o.baddr ||
                             o_bus_be !== o.bbe || o_bus_wdata !== o.bwdata) begin
                    o.stable = 1'b0;
                end
                i_bus_ack   = (o.req_cycles == ack_at);
                i_bus_rdata = brd;
            end else begin
                i_bus_ack = 1'b0;
            end
            tick();
        end
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'h0;
        tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_mem_req = 1'b0; i_mem_we = 1'b0; i_dm_type = 3'b000;
        i_addr = 32'h0; i_wdata = 32'h0; i_bus_rdata = 32'h0; i_bus_ack = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        n_checks++;
        if ({o_busy, o_done, o_err, o_bus_req, o_bus_we} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b expected 00000", {o_busy, o_done, o_err, o_bus_req, o_bus_we});
        else n_pass++;
        n_checks++;
        if ({o_rdata, o_bus_addr, o_bus_be, o_bus_wdata} !== 100'h0)
            $display("FAIL reset_data: rdata %h addr %h be %b wdata %h expected all zero",
                     o_rdata, o_bus_addr, o_bus_be, o_bus_wdata);
        else n_pass++;
    endtask

    task automatic test_stores();
        obs_t o;
        exp_t e;
        // Store word, ack in first REQ cycle.
        sb_q.push_back('{2, 1'b0, 32'h0});
        run_access(1'b1, 3'b000, 32'h100, 32'hDEAD_BEEF, 1, 32'h0, o);
        e = sb_q.pop_front();
        n_checks++;
        if (!o.done_seen || o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata)
            $display("FAIL sw_done: seen %0b lat %0d err %b rdata %h expected lat %0d err %b rdata %h",
                     o.done_seen, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
        else n_pass++;
        n_checks++;
        if (o.bwe !== 1'b1 || o.baddr !== 32'h100 || o.bbe !== 4'b1111 ||
            o.bwdata !== 32'hDEAD_BEEF || o.req_cycles != 1)
            $display("FAIL sw_bus: we %b addr %h be %b wdata %h req %0d expected 1 00000100 1111 deadbeef 1",
                     o.bwe, o.baddr, o.bbe, o.bwdata, o.req_cycles);
        else n_pass++;
        n_checks++;
        if (o.busy !== 1'b1)
            $display("FAIL sw_busy_at_done: got %b expected 1", o.busy);
        else n_pass++;

        // Store byte 0x5A at 0x103.
        sb_q.push_back('{2, 1'b0, 32'h0});
        run_access(1'b1, 3'b011, 32'h103, 32'h1234_565A, 1, 32'h0, o);
        e = sb_q.pop_front();
        n_checks++;
        if (!o.done_seen || o.lat != e.lat || o.err !== e.err ||
            o.bbe !== 4'b1000 || o.bwdata !== 32'h5A5A_5A5A || o.baddr !== 32'h100)
            $display("FAIL sb: lat %0d err %b be %b wdata %h addr %h expected %0d 0 1000 5a5a5a5a 00000100",
                     o.lat, o.err, o.bbe, o.bwdata, o.baddr, e.lat);
        else n_pass++;

        // Store half at 0x102.
        sb_q.push_back('{2, 1'b0, 32'h0});
        run_access(1'b1, 3'b001, 32'h102, 32'hABCD_1234, 1, 32'h0, o);
        e = sb_q.pop_front();
        n_checks++;
        if (!o.done_seen || o.lat != e.lat || o.err !== e.err ||
            o.bbe !== 4'b1100 || o.bwdata !== 32'h1234_1234 || o.baddr !== 32'h100)
            $display("FAIL sh: lat %0d err %b be %b wdata %h addr %h expected %0d 0 1100 12341234 00000100",
                     o.lat, o.err, o.bbe, o.bwdata, o.baddr, e.lat);
        else n_pass++;
    endtask

    task automatic test_loads();
        logic [2:0]  t_tab  [8] = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b000, 3'b011, 3'b100, 3'b001};
        logic [31:0] a_tab  [8] = '{32'h100, 32'h100, 32'h102, 32'h102, 32'h100, 32'h101, 32'h103, 32'h100};
        logic [31:0] r_tab  [8] = '{32'hFFFF_FF82, 32'h0000_0082, 32'hFFFF_80F1, 32'h0000_80F1,
                                    32'h80F1_7F82, 32'h0000_007F, 32'h0000_0080, 32'h0000_7F82};
        logic [3:0]  be_tab [8] = '{4'b0001, 4'b0001, 4'b1100, 4'b1100, 4'b1111, 4'b0010, 4'b1000, 4'b0011};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{2, 1'b0, r_tab[i]});
            run_access(1'b0, t_tab[i], a_tab[i], 32'hFFFF_FFFF, 1, 32'h80F1_7F82, o);
            e = sb_q.pop_front();
            n_checks++;
            if (!o.done_seen || o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata)
                $display("FAIL load_%0d: seen %0b lat %0d err %b rdata %h expected lat %0d err 0 rdata %h",
                         i, o.done_seen, o.lat, o.err, o.rdata, e.lat, e.rdata);
            else n_pass++;
            n_checks++;
            if (o.bwe !== 1'b0 || o.bbe !== be_tab[i] || o.baddr !== 32'h100)
                $display("FAIL load_bus_%0d: we %b be %b addr %h expected 0 %b 00000100",
                         i, o.bwe, o.bbe, o.baddr, be_tab[i]);
            else n_pass++;
        end
        // Result must persist after the done pulse.
        n_checks++;
        if (o_rdata !== 32'h0000_7F82 || o_done !== 1'b0)
            $display("FAIL rdata_hold: rdata %h done %b expected 00007f82 0", o_rdata, o_done);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic        we_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  t_tab  [4] = '{3'b000, 3'b001, 3'b110, 3'b100};
        logic [31:0] a_tab  [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{1, 1'b1, 32'h0});
            run_access(we_tab[i], t_tab[i], a_tab[i], 32'h1111_2222, 1, 32'h3333_4444, o);
            e = sb_q.pop_front();
            n_checks++;
            if (!o.done_seen || o.lat != e.lat || o.err !== e.err ||
                o.rdata !== e.rdata || o.req_cycles != 0)
                $display("FAIL illegal_%0d: seen %0b lat %0d err %b rdata %h req %0d expected lat 1 err 1 rdata 0 req 0",
                         i, o.done_seen, o.lat, o.err, o.rdata, o.req_cycles);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sb_q.push_back('{1 + int'(TO), 1'b1, 32'h0});
        run_access(1'b0, 3'b000, 32'h200, 32'h0, 0, 32'h1357_9BDF, o);
        e = sb_q.pop_front();
        n_checks++;
        if (!o.done_seen || o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata)
            $display("FAIL timeout_done: seen %0b lat %0d err %b rdata %h expected lat %0d err 1 rdata 0",
                     o.done_seen, o.lat, o.err, o.rdata, e.lat);
        else n_pass++;
        n_checks++;
        if (o.req_cycles != int'(TO) || o.stable !== 1'b1)
            $display("FAIL timeout_req: req cycles %0d stable %b expected %0d 1", o.req_cycles, o.stable, TO);
        else n_pass++;

        // Ack in the final watchdog cycle completes normally.
        sb_q.push_back('{1 + int'(TO), 1'b0, 32'h1357_9BDF});
        run_access(1'b0, 3'b000, 32'h200, 32'h0, int'(TO), 32'h1357_9BDF, o);
        e = sb_q.pop_front();
        n_checks++;
        if (!o.done_seen || o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata ||
            o.req_cycles != int'(TO) || o.stable !== 1'b1)
            $display("FAIL late_ack: seen %0b lat %0d err %b rdata %h req %0d stable %b expected lat %0d err 0 rdata %h req %0d",
                     o.done_seen, o.lat, o.err, o.rdata, o.req_cycles, o.stable, e.lat, e.rdata, TO);
        else n_pass++;

        // Two wait cycles before ack.
        sb_q.push_back('{3, 1'b0, 32'hFFFF_FFA5});
        run_access(1'b0, 3'b011, 32'h201, 32'h0, 2, 32'h0000_A500, o);
        e = sb_q.pop_front();
        n_checks++;
        if (!o.done_seen || o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata)
            $display("FAIL ack_wait: lat %0d err %b rdata %h expected lat %0d err 0 rdata %h",
                     o.lat, o.err, o.rdata, e.lat, e.rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        exp_t e;
        sb_q.push_back('{2, 1'b0, 32'h0});
        sb_q.push_back('{2, 1'b0, 32'h0000_00C3});
        run_access(1'b1, 3'b000, 32'h300, 32'hCAFE_F00D, 1, 32'h0, o1);
        run_access(1'b0, 3'b100, 32'h302, 32'h0, 1, 32'h00C3_0000, o2);
        e = sb_q.pop_front();
        n_checks++;
        if (!o1.done_seen || o1.lat != e.lat || o1.err !== e.err)
            $display("FAIL b2b_first: lat %0d err %b expected %0d 0", o1.lat, o1.err, e.lat);
        else n_pass++;
        e = sb_q.pop_front();
        n_checks++;
        if (!o2.done_seen || o2.lat != e.lat || o2.rdata !== e.rdata ||
            (o2.done_cyc - o1.done_cyc) != 3)
            $display("FAIL b2b_second: lat %0d rdata %h spacing %0d expected %0d %h 3",
                     o2.lat, o2.rdata, o2.done_cyc - o1.done_cyc, e.lat, e.rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        logic seen;
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_dm_type = 3'b000;
        i_addr = 32'h400; i_wdata = 32'h0;
        tick();
        i_mem_req = 1'b0;
        n_checks++;
        if (o_bus_req !== 1'b1 || o_busy !== 1'b1)
            $display("FAIL mid_req: bus_req %b busy %b expected 1 1", o_bus_req, o_busy);
        else n_pass++;
        #2;
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_bus_req !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0)
            $display("FAIL mid_rst_async: bus_req %b busy %b done %b expected 0 0 0", o_bus_req, o_busy, o_done);
        else n_pass++;
        tick();
        i_rst = 1'b0;
        i_bus_ack = 1'b1;
        i_bus_rdata = 32'hFFFF_FFFF;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (o_done !== 1'b0 || o_busy !== 1'b0) seen = 1'b1;
        end
        i_bus_ack = 1'b0;
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL stray_ack: activity after reset got %b expected 0", seen);
        else n_pass++;
        sb_q.push_back('{2, 1'b0, 32'h0BAD_F00D});
        run_access(1'b0, 3'b000, 32'h404, 32'h0, 1, 32'h0BAD_F00D, o);
        e = sb_q.pop_front();
        n_checks++;
        if (!o.done_seen || o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata)
            $display("FAIL after_rst: lat %0d err %b rdata %h expected %0d 0 %h",
                     o.lat, o.err, o.rdata, e.lat, e.rdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Sequential load/store unit between the datapath and a handshaked data-memory bus. Consumes the decoder's `MemWrite` and `DMType` together with the ALU-computed address and rs2 data. Performs byte/halfword/word alignment, byte-enable generation and load sign/zero extension. Runs one bus transaction per access, with a timeout watchdog, and stalls the core through `busy` until completion.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles `bus_req` stays high without `bus_ack` before the access is aborted; legal range 2..255.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_req` in 1: single-cycle access request; sampled only in IDLE.
- `mem_we` in 1: 1 = store, 0 = load (the decoder's MemWrite).
- `dm_type` in 3: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- `addr` in 32: byte address.
- `wdata` in 32: store data, taken from its low bits.
- `busy` out 1: access in progress; the core holds the PC and pipeline while high.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; access was misaligned, illegal or timed out.
- `rdata` out 32: extended load result, valid while `done`=1 and held until the next `done`.
- `bus_req` out 1: bus request, held until ack or timeout.
- `bus_we` out 1: bus write strobe.
- `bus_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_ack` in 1: transaction complete; ignored unless `bus_req`=1.

## Operation
- States: IDLE, REQ, RESP, FAIL.
- IDLE, `mem_req`=1:
  - If the access is legal and aligned, latch `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, addr[1:0] and `dm_type`, then go to REQ.
  - Otherwise go to FAIL with no bus activity.
- IDLE, `mem_req`=0: stay in IDLE.
- Illegal cases:
  - `dm_type` 101/110/111, for loads or stores.
  - Store with `dm_type` 010 or 100.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- Byte enables:
  - Word: 1111.
  - Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Byte: 0001 shifted left by addr[1:0].
- Store data:
  - Word: `wdata`.
  - Half: {wdata[15:0], wdata[15:0]}.
  - Byte: wdata[7:0] replicated into all four lanes.
- REQ:
  - `bus_req`=1.
  - On `bus_ack`=1: capture `bus_rdata`, go to RESP, clear the watchdog.
  - Else increment the watchdog; when it reaches TIMEOUT, drop `bus_req` and go to FAIL.
- RESP:
  - `done`=1, `err`=0.
  - Loads: `rdata` = selected lane, sign-extended (001, 011) or zero-extended (010, 100).
  - Stores: `rdata`=0.
  - Go to IDLE.
- FAIL: `done`=1, `err`=1, `rdata`=0, go to IDLE.
- `busy`=1 in REQ, RESP and FAIL.
- `mem_req` in any non-IDLE state is ignored and not queued.

## Timing
- Reset values:
  - State IDLE, watchdog 0.
  - `busy`, `done`, `err`, `bus_req`, `bus_we` = 0.
  - `rdata`, `bus_addr`, `bus_be`, `bus_wdata` = 0.
- Reset mid-access: outputs return to reset values immediately (asynchronous). An outstanding bus transaction is abandoned, and a later `bus_ack` is ignored.
- Timeline, with the request accepted at edge E0:
  - `bus_req` is high from the cycle after E0.
  - With ack in the first REQ cycle, `done` is high in the following cycle, giving 2 cycles from `mem_req` to `done`.
  - Each ack wait cycle adds one cycle.
- Illegal access: `done`/`err` in the cycle after `mem_req`; `bus_req` never asserts.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles, then `done`/`err` appear in the next cycle.
- Ack arriving in the same cycle the watchdog expires: the ack wins and the access completes normally.
- All bus_* outputs are registered and stable for the whole REQ period.
- `done`, `err` and `rdata` are registered; `busy` is decoded from state.
- Back-to-back: a `mem_req` in the cycle after `done` is accepted, so a new access can start every 3 cycles.

## Test plan
- Store word 0xDEADBEEF at 0x100, ack in the first REQ cycle:
  - `bus_be`=1111, `bus_addr`=0x100, `bus_we`=1.
  - `done` arrives 2 cycles after `mem_req`, with `err`=0.
- Store byte 0x5A at 0x103: `bus_be`=1000, `bus_wdata`=0x5A5A5A5A, `bus_addr`=0x100.
- Loads with `bus_rdata`=0x80F1_7F82:
  - lb @0x100 → 0xFFFFFF82; lbu @0x100 → 0x00000082.
  - lh @0x102 → 0xFFFF80F1; lhu @0x102 → 0x000080F1.
  - lw @0x100 → 0x80F17F82.
- Illegal accesses: lw @0x102, sh @0x101 and `dm_type`=110 each give `done`+`err` 1 cycle later with no `bus_req`.
- Timeout with TIMEOUT=4 and `bus_ack` held low:
  - `bus_req` is high for exactly 4 cycles, then `done`+`err` follow.
  - A repeat with ack in the 4th cycle completes with `err`=0.
- Assert `rst` while in REQ: `bus_req` and `busy` drop immediately. A subsequent stray `bus_ack` produces no `done`, and the next `mem_req` is accepted normally.
